// File: rtl/sift_pkg.sv
// Shared constants and types for the SIFT front-end greyscale stage.
// Holds the BT.601-style luma weights (scaled by 2^LUMA_SHIFT) and the converter FSM states.
package sift_pkg;

   localparam int LUMA_KR    = 77;
   localparam int LUMA_KG    = 150;
   localparam int LUMA_KB    = 29;
   localparam int LUMA_SHIFT = 8;
   localparam int LUMA_ACC_W = 17;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } grey_state_t;

endpackage

// File: rtl/bram_greyscale_converter_rgb_to_luma.sv
// Combinational packed-RGB to luma: channel expansion to 8 bits, weighted sum, round-half-up.
// Output is the top OUT_W bits of the 8-bit luma; the caller registers it.
module rgb_to_luma
   import sift_pkg::*;
#(
   parameter int CH_W  = 4,
   parameter int OUT_W = 8
) (
   input  logic [3*CH_W-1:0] pixel,
   output logic [OUT_W-1:0]  luma
);

   // Repeating the channel bits makes full scale map to 0xFF exactly.
   function automatic logic [7:0] expand(input logic [CH_W-1:0] c);
      logic [7:0] e;
      for (int i = 0; i < 8; i++) begin
         e[7-i] = c[CH_W-1-(i % CH_W)];
      end
      return e;
   endfunction

   function automatic logic [7:0] round_shift(input logic [LUMA_ACC_W-1:0] acc);
      return 8'((acc + LUMA_ACC_W'(1 << (LUMA_SHIFT - 1))) >> LUMA_SHIFT);
   endfunction

   logic [7:0]            r8, g8, b8;
   logic [LUMA_ACC_W-1:0] acc;
   logic [7:0]            y8;

   always_comb begin
      r8  = expand(pixel[3*CH_W-1 -: CH_W]);
      g8  = expand(pixel[2*CH_W-1 -: CH_W]);
      b8  = expand(pixel[CH_W-1 -: CH_W]);
      acc = LUMA_ACC_W'(LUMA_KR) * LUMA_ACC_W'(r8)
          + LUMA_ACC_W'(LUMA_KG) * LUMA_ACC_W'(g8)
          + LUMA_ACC_W'(LUMA_KB) * LUMA_ACC_W'(b8);
      y8  = round_shift(acc);
   end

   assign luma = y8[7 -: OUT_W];

endmodule

// File: rtl/bram_greyscale_converter.sv
// Frame-level RGB->greyscale engine: scans the source BRAM once per start pulse and writes luma
// to the same address in the destination BRAM. Optional per-frame min/max via GREY_STATS_EN.
module bram_greyscale_converter
   import sift_pkg::*;
#(
   parameter  int IMG_W  = 128,
   parameter  int IMG_H  = 128,
   parameter  int CH_W   = 4,
   parameter  int OUT_W  = 8,
   parameter  int RD_LAT = 2,
   localparam int N      = IMG_W * IMG_H,
   localparam int AW     = $clog2(N)
) (
   input  logic              clk_100mhz,
   input  logic              sys_rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     rd_addr,
   input  logic [3*CH_W-1:0] rd_data,
   output logic [AW-1:0]     wr_addr,
   output logic [OUT_W-1:0]  wr_data,
   output logic              wr_en,
   output logic [OUT_W-1:0]  px_min,
   output logic [OUT_W-1:0]  px_max
);

   // Reset asserts immediately, releases two clocks after sys_rst_n rises.
   logic rst_meta, rst_n;

   always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   grey_state_t      state, state_nxt;
   logic             accept, last_addr, issue, pipe_empty;
   logic [RD_LAT:0]  vld_p;
   logic [AW-1:0]    addr_p [RD_LAT];
   logic [OUT_W-1:0] luma;

   assign accept     = (state == IDLE) && start;
   assign last_addr  = (rd_addr == AW'(N - 1));
   assign issue      = accept || ((state == SCAN) && !last_addr);
   assign pipe_empty = ~|vld_p;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)      state_nxt = SCAN;
         SCAN:    if (last_addr)  state_nxt = DRAIN;
         DRAIN:   if (pipe_empty) state_nxt = DONE;
         DONE:                    state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // p0: address issue; vld_p[0] marks the address currently on rd_addr
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr <= '0;
         vld_p   <= '0;
      end else begin
         vld_p <= {vld_p[RD_LAT-1:0], issue};
         if (accept)
            rd_addr <= '0;
         else if (issue)
            rd_addr <= rd_addr + AW'(1);
      end
   end

   // p1..pRD_LAT: address travels alongside the BRAM read latency
   always_ff @(posedge clk_100mhz) begin
      addr_p[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         addr_p[i] <= addr_p[i-1];
      end
   end

   rgb_to_luma #(
      .CH_W  (CH_W),
      .OUT_W (OUT_W)
   ) u_luma (
      .pixel (rd_data),
      .luma  (luma)
   );

   // write stage: rd_data is valid while vld_p[RD_LAT] is high
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= vld_p[RD_LAT];
         if (vld_p[RD_LAT]) begin
            wr_addr <= addr_p[RD_LAT-1];
            wr_data <= luma;
         end
      end
   end

`ifdef GREY_STATS_EN
   // Running values double as the held frame result until the next accepted start.
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         px_min <= '0;
         px_max <= '0;
      end else if (accept) begin
         px_min <= '1;
         px_max <= '0;
      end else if (wr_en) begin
         if (wr_data < px_min) px_min <= wr_data;
         if (wr_data > px_max) px_max <= wr_data;
      end
   end
`else
   assign px_min = '0;
   assign px_max = '0;
`endif

endmodule
